fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the non-pipelined LEGv8 core. Holds the PC and requests 32-bit instruction words from instruction memory over a req/ack handshake. Presents the fetched word and its opcode field to the decode/control stage. Computes the next PC on retirement: sequential, or the branch target supplied by the datapath.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `MAX_WAIT`, default 16: cycles `imem_req` may stay high without `imem_ack` before a timeout fault; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  64  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction word.
- `opcode`  out  11  `instr[31:21]`; feeds control decode.
- `instr_valid`  out  1  `instr`/`opcode`/`pc` are valid for the datapath.
- `pc`  out  64  address of the current (held or requested) instruction.
- `retire`  in  1  datapath has finished the current instruction; ignored unless `instr_valid`=1.
- `branch_taken`  in  1  sampled with `retire`; select `branch_target` as next PC.
- `branch_target`  in  64  sampled with `retire`.
- `fault`  out  1  sticky fault indication.
- `fault_code`  out  2  00 none, 01 fetch timeout, 10 misaligned branch target.

## Operation
- States: FETCH, HOLD, FAULT.
- Reset values: state=FETCH, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `fault`=0, `fault_code`=00, wait counter=0. `imem_req` is registered and resets to 0, then goes to 1 on the first edge after reset deasserts.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`. Counter increments each cycle without ack.
  - `imem_ack`=1: latch `imem_rdata` into `instr`, clear counter, go to HOLD.
  - Counter reaches `MAX_WAIT` without ack: go to FAULT with code 01.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0. `instr` and `pc` are stable.
  - `retire`=1: next = `branch_taken` ? `branch_target` : `pc`+4. Addition is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
  - Next PC bits [1:0] ≠ 00: go to FAULT with code 10; `pc` keeps the retiring instruction's address.
  - Otherwise: `pc` ← next, go to FETCH.
- FAULT: `fault`=1, `imem_req`=0, `instr_valid`=0. All inputs are ignored; the only exit is `reset`.
- `branch_taken`=1 and `branch_target`=`pc` is legal (self-loop).
- `retire` or `branch_taken` outside HOLD has no effect.
- `imem_ack` while `imem_req`=0 has no effect.
- `reset` mid-fetch or mid-hold:
  - Outstanding request is abandoned and outputs return to reset values asynchronously.
  - Memory must tolerate a dropped request.

## Timing
- Ack sampled at edge N: `instr_valid`=1 and `imem_req`=0 from N+1.
- Retire sampled at edge M: `instr_valid`=0, `imem_req`=1 and new `pc` from M+1.
- Minimum instruction period: 2 cycles (zero-wait memory, `retire` asserted in the first HOLD cycle).
- Timeout: with no ack, FAULT is entered exactly `MAX_WAIT` cycles after `imem_req` rises.
- Outputs are registered; `opcode` is a combinational slice of registered `instr`.
- No combinational path from any input to any output.

## Structure
- `constants.vh` gains:
  - state encodings `FETCH_S`, `HOLD_S`, `FAULT_S`;
  - fault codes `FAULT_NONE`, `FAULT_TIMEOUT`, `FAULT_MISALIGN`;
  - `OPCODE_MSB`/`OPCODE_LSB` (31/21), shared with control decode;
  - `INSTR_BYTES` (4).
- One sub-module, `pc_next_sel`: combinational next-PC select (+4 vs target) and alignment check. It outputs `next_pc` and `misaligned`.

## Test plan
- Reset release, memory acks on 1st request cycle with 0x8B020020 → `imem_addr`=0; next cycle `instr_valid`=1, `opcode`=11'h458; `imem_req`=0.
- Retire with `branch_taken`=0 at `pc`=0x10 → next cycle `pc`=0x14, `imem_req`=1.
- Retire with `branch_taken`=1, target 0x40 → `pc`=0x40 next cycle. With target 0x42 → FAULT, `fault_code`=10, `pc` stays at old value, `imem_req` stays 0 indefinitely.
- `MAX_WAIT`=4, memory never acks → `fault`=1 with code 01 exactly 4 cycles after `imem_req` rises. Later acks and retires have no effect.
- `pc`=0xFFFF_FFFF_FFFF_FFFC, sequential retire → `pc`=0. Also: spurious `retire` during FETCH and spurious `imem_ack` during HOLD → no state change.
- Assert `reset` asynchronously mid-HOLD and mid-FETCH → outputs are at reset values before the next edge; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the LEGv8 fetch stage: FSM state encodings, fault
// codes, opcode field position and instruction size, plus small helper
// functions used by the fetch unit and its next-PC selector.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_S = 2'b00,
        HOLD_S  = 2'b01,
        FAULT_S = 2'b10
    } fetch_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    // Opcode field position, shared with control decode.
    localparam int OPCODE_MSB  = 31;
    localparam int OPCODE_LSB  = 21;
    localparam int INSTR_BYTES = 4;

    // Extract the 11-bit opcode field from an instruction word.
    function automatic logic [10:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // A fetch address is legal only when it is 4-byte aligned.
    function automatic logic word_misaligned(input logic [63:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// pc_next_sel
// Combinational next-PC selection for the fetch unit: sequential (pc + 4,
// modulo 2^64) or the datapath-supplied branch target, plus an alignment
// check on the selected address.
// Ports:
//   pc            in  64  address of the retiring instruction
//   branch_taken  in  1   select branch_target instead of pc + 4
//   branch_target in  64  branch destination from the datapath
//   next_pc       out 64  selected next PC
//   misaligned    out 1   next_pc[1:0] is non-zero
module pc_next_sel
    import fetch_unit_pkg::*;
(
    input  logic [63:0] pc,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] next_pc,
    output logic        misaligned
);

    // Select the next PC and flag a misaligned destination.
    always_comb begin
        next_pc    = 64'h0;
        misaligned = 1'b0;
        if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            // Natural 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFC + 4 = 0.
            next_pc = pc + 64'(INSTR_BYTES);
        end
        misaligned = word_misaligned(next_pc);
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage of the non-pipelined LEGv8 core. Holds the PC,
// fetches 32-bit words over a req/ack handshake, presents the word to the
// datapath and advances the PC when the datapath retires the instruction.
// Fetch timeouts and misaligned branch targets lock the unit in a sticky
// FAULT state that only reset leaves.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   imem_req/addr           fetch request and address (addr == pc)
//   imem_ack/rdata          memory response, used only while imem_req=1
//   instr, opcode           held instruction word and its opcode field
//   instr_valid, pc         instruction valid flag and its address
//   retire                  datapath done with the current instruction
//   branch_taken/target     next-PC select, sampled with retire
//   fault, fault_code       sticky fault flag and cause
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [10:0] opcode,
    output logic        instr_valid,
    output logic [63:0] pc,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        fault,
    output logic [1:0]  fault_code
);

    // Counter value at which one more ack-less cycle means timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state_r;
    logic         req_r;
    logic [63:0]  pc_r;
    logic [31:0]  instr_r;
    logic         valid_r;
    logic         fault_r;
    logic [1:0]   fault_code_r;
    logic [7:0]   wait_cnt_r;

    logic [63:0]  next_pc_s;
    logic         misaligned_s;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_r),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc_s),
        .misaligned    (misaligned_s)
    );

    // Fetch FSM: all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= FETCH_S;
            req_r        <= 1'b0;
            pc_r         <= RESET_PC;
            instr_r      <= 32'h0;
            valid_r      <= 1'b0;
            fault_r      <= 1'b0;
            fault_code_r <= FAULT_NONE;
            wait_cnt_r   <= 8'h0;
        end else begin
            case (state_r)
                FETCH_S: begin
                    if (!req_r) begin
                        // First cycle after reset: raise the request; any
                        // ack seen while req is low is ignored.
                        req_r      <= 1'b1;
                        wait_cnt_r <= 8'h0;
                    end else if (imem_ack) begin
                        instr_r    <= imem_rdata;
                        valid_r    <= 1'b1;
                        req_r      <= 1'b0;
                        wait_cnt_r <= 8'h0;
                        state_r    <= HOLD_S;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        req_r        <= 1'b0;
                        fault_r      <= 1'b1;
                        fault_code_r <= FAULT_TIMEOUT;
                        state_r      <= FAULT_S;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                HOLD_S: begin
                    if (retire && misaligned_s) begin
                        // pc keeps the retiring instruction's address.
                        valid_r      <= 1'b0;
                        fault_r      <= 1'b1;
                        fault_code_r <= FAULT_MISALIGN;
                        state_r      <= FAULT_S;
                    end else if (retire) begin
                        // Request goes out in the same edge as the new PC.
                        pc_r       <= next_pc_s;
                        valid_r    <= 1'b0;
                        req_r      <= 1'b1;
                        wait_cnt_r <= 8'h0;
                        state_r    <= FETCH_S;
                    end else begin
                        state_r <= HOLD_S;
                    end
                end
                FAULT_S: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    fault_r <= 1'b1;
                    state_r <= FAULT_S;
                end
                default: begin
                    // Corrupted state encoding: park safely in FAULT.
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    fault_r <= 1'b1;
                    state_r <= FAULT_S;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign opcode      = opcode_of(instr_r);
    assign instr_valid = valid_r;
    assign fault       = fault_r;
    assign fault_code  = fault_code_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit (MAX_WAIT=4, RESET_PC=0). Inputs change 1 ns
// after a rising edge; outputs are checked at that same point, so each check
// observes the result of the preceding edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic        instr_valid;
    logic [63:0] pc;
    logic        retire;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        fault;
    logic [1:0]  fault_code;

    int vectors     = 0;
    int miscompares = 0;

    fetch_unit #(.RESET_PC(64'h0), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .retire        (retire),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   64'(imem_req),    64'h0);
        chk({tag, "_valid"}, 64'(instr_valid), 64'h0);
        chk({tag, "_pc"},    pc,               64'h0);
        chk({tag, "_instr"}, 64'(instr),       64'h0);
        chk({tag, "_fault"}, 64'(fault),       64'h0);
        chk({tag, "_code"},  64'(fault_code),  64'h0);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        retire = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        tick(); tick();
        chk_reset_vals("rst");

        // First fetch: ack on the first request cycle.
        reset = 1'b0;
        tick();
        chk("f0_req",  64'(imem_req),  64'h1);
        chk("f0_addr", imem_addr,      64'h0);
        imem_ack = 1'b1; imem_rdata = 32'h8B020020;
        tick();
        chk("f0_valid",  64'(instr_valid), 64'h1);
        chk("f0_opcode", 64'(opcode),      64'h458);
        chk("f0_req_lo", 64'(imem_req),    64'h0);
        chk("f0_instr",  64'(instr),       64'h8B020020);
        imem_ack = 1'b0;

        // Branch to 0x10, fetch, then sequential retire to 0x14.
        retire = 1'b1; branch_taken = 1'b1; branch_target = 64'h10;
        tick();
        chk("br10_pc",    pc,                64'h10);
        chk("br10_req",   64'(imem_req),     64'h1);
        chk("br10_valid", 64'(instr_valid),  64'h0);
        retire = 1'b0; branch_taken = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hF84003E0;
        tick();
        imem_ack = 1'b0; retire = 1'b1;
        tick();
        chk("seq_pc",  pc,            64'h14);
        chk("seq_req", 64'(imem_req), 64'h1);
        // retire still high while fetching: must be ignored.
        tick();
        chk("spr_ret_pc",    pc,               64'h14);
        chk("spr_ret_req",   64'(imem_req),    64'h1);
        chk("spr_ret_valid", 64'(instr_valid), 64'h0);
        retire = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hD65F03C0;
        tick();
        chk("f2_instr", 64'(instr), 64'hD65F03C0);
        // Spurious ack during HOLD: nothing changes.
        imem_rdata = 32'h12345678;
        tick();
        chk("spr_ack_instr", 64'(instr),       64'hD65F03C0);
        chk("spr_ack_valid", 64'(instr_valid), 64'h1);
        chk("spr_ack_req",   64'(imem_req),    64'h0);
        chk("spr_ack_pc",    pc,               64'h14);
        imem_ack = 1'b0;

        // Taken branch to 0x40, then a self-loop at 0x40.
        retire = 1'b1; branch_taken = 1'b1; branch_target = 64'h40;
        tick();
        chk("br40_pc", pc, 64'h40);
        retire = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h91000421;
        tick();
        imem_ack = 1'b0; retire = 1'b1;
        tick();
        chk("self_pc",  pc,            64'h40);
        chk("self_req", 64'(imem_req), 64'h1);

        // PC wrap from the top of the address space.
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC; imem_ack = 1'b1; retire = 1'b0;
        tick();
        imem_ack = 1'b0; retire = 1'b1;
        tick();
        chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        retire = 1'b0; branch_taken = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0; retire = 1'b1;
        tick();
        chk("wrap_pc",  pc,            64'h0);
        chk("wrap_req", 64'(imem_req), 64'h1);
        retire = 1'b0; imem_ack = 1'b1;
        tick();

        // Misaligned branch target -> sticky FAULT, pc unchanged.
        imem_ack = 1'b0; retire = 1'b1; branch_taken = 1'b1; branch_target = 64'h42;
        tick();
        chk("mis_fault", 64'(fault),       64'h1);
        chk("mis_code",  64'(fault_code),  64'h2);
        chk("mis_pc",    pc,               64'h0);
        chk("mis_req",   64'(imem_req),    64'h0);
        chk("mis_valid", 64'(instr_valid), 64'h0);
        imem_ack = 1'b1; branch_target = 64'h80;
        tick(); tick(); tick();
        chk("mis_hold_code", 64'(fault_code), 64'h2);
        chk("mis_hold_req",  64'(imem_req),   64'h0);
        chk("mis_hold_pc",   pc,              64'h0);
        imem_ack = 1'b0; retire = 1'b0; branch_taken = 1'b0;

        // Asynchronous reset out of FAULT.
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_fault");
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hAAAA5555;
        tick();
        imem_ack = 1'b0;
        chk("pre_hold_valid", 64'(instr_valid), 64'h1);
        // Asynchronous reset mid-HOLD, checked before the next edge.
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        tick();
        reset = 1'b0;
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0; retire = 1'b1; branch_taken = 1'b1; branch_target = 64'h80;
        tick();
        retire = 1'b0; branch_taken = 1'b0;
        chk("pre_fetch_pc", pc, 64'h80);
        // Asynchronous reset mid-FETCH.
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("rst_fetch");
        tick();
        reset = 1'b0;

        // Timeout: request rises, no ack; fault exactly 4 cycles later.
        tick();
        chk("to_req_rise", 64'(imem_req),  64'h1);
        chk("to_addr",     imem_addr,      64'h0);
        tick(); tick(); tick();
        chk("to_pre_fault", 64'(fault),    64'h0);
        chk("to_pre_req",   64'(imem_req), 64'h1);
        tick();
        chk("to_fault", 64'(fault),      64'h1);
        chk("to_code",  64'(fault_code), 64'h1);
        chk("to_req",   64'(imem_req),   64'h0);
        imem_ack = 1'b1; retire = 1'b1; branch_taken = 1'b1; branch_target = 64'h40;
        tick(); tick(); tick();
        chk("to_hold_code",  64'(fault_code),  64'h1);
        chk("to_hold_valid", 64'(instr_valid), 64'h0);
        chk("to_hold_pc",    pc,               64'h0);
        chk("to_hold_req",   64'(imem_req),    64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
